// File: rtl/div_ctrl.sv
// Divider arbiter: round-robin issue of NUM_REQ requesters onto one
// iterative divider, one-entry repeat cache, result hold, watchdog.
// Ports: clk_i/rst_ni, flush_ex_i, req_* (per requester), div_* (divider
// side), wb_* (writeback valid/ready), busy_o, err_o.
module div_ctrl #(
  parameter int NUM_REQ   = 2,
  parameter bit CACHE_EN  = 1'b1,
  parameter int MAX_LAT   = 40,
  parameter int OP_W      = 2,
  parameter int ADDR_BITS = 4,
  parameter int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_ex_i,
  input  logic [NUM_REQ-1:0]          req_vld_i,
  output logic [NUM_REQ-1:0]          req_rdy_o,
  input  logic [NUM_REQ*OP_W-1:0]     req_op_i,
  input  logic [NUM_REQ*32-1:0]       req_op1_i,
  input  logic [NUM_REQ*32-1:0]       req_op2_i,
  input  logic [NUM_REQ*ADDR_BITS-1:0] req_trans_id_i,
  output logic                        div_vld_o,
  input  logic                        div_rdy_i,
  output logic [OP_W-1:0]             div_op_o,
  output logic [31:0]                 div_op1_o,
  output logic [31:0]                 div_op2_o,
  output logic [ADDR_BITS-1:0]        div_trans_id_o,
  input  logic                        div_vld_i,
  input  logic [ADDR_BITS-1:0]        div_trans_id_i,
  input  logic [31:0]                 div_result_i,
  output logic                        wb_vld_o,
  input  logic                        wb_rdy_i,
  output logic [ADDR_BITS-1:0]        wb_trans_id_o,
  output logic [31:0]                 wb_result_o,
  output logic [SRC_W-1:0]            wb_src_o,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int WD_W = $clog2(MAX_LAT + 1);

  logic [1:0]           state_q;
  logic [SRC_W-1:0]     rr_q;
  logic [OP_W-1:0]      lat_op_q;
  logic [31:0]          lat_op1_q;
  logic [31:0]          lat_op2_q;
  logic [SRC_W-1:0]     lat_src_q;
  logic [31:0]          buf_res_q;
  logic [ADDR_BITS-1:0] buf_id_q;
  logic [SRC_W-1:0]     buf_src_q;
  logic                 c_vld_q;
  logic [OP_W-1:0]      c_op_q;
  logic [31:0]          c_op1_q;
  logic [31:0]          c_op2_q;
  logic [31:0]          c_res_q;
  logic [WD_W-1:0]      wd_q;
  logic                 err_q;

  logic [OP_W-1:0]      op_a  [NUM_REQ];
  logic [31:0]          op1_a [NUM_REQ];
  logic [31:0]          op2_a [NUM_REQ];
  logic [ADDR_BITS-1:0] id_a  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_a[g]  = req_op_i[g*OP_W +: OP_W];
    assign op1_a[g] = req_op1_i[g*32 +: 32];
    assign op2_a[g] = req_op2_i[g*32 +: 32];
    assign id_a[g]  = req_trans_id_i[g*ADDR_BITS +: ADDR_BITS];
  end

  logic             found;
  logic [SRC_W-1:0] win;
  logic [SRC_W:0]   idx;

  // Scan from rr_q upward with wrap; first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_q} + (SRC_W+1)'(i);
      if (idx >= (SRC_W+1)'(NUM_REQ)) begin
        idx = idx - (SRC_W+1)'(NUM_REQ);
      end
      if (!found && req_vld_i[idx[SRC_W-1:0]]) begin
        found = 1'b1;
        win   = idx[SRC_W-1:0];
      end
    end
  end

  logic [SRC_W-1:0] rr_nxt;
  assign rr_nxt = (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  logic grant_ok;
  logic hit;
  logic issue;
  logic accept;

  assign grant_ok = rst_ni && !flush_ex_i
                 && (state_q == IDLE) && found;

  assign hit = CACHE_EN && c_vld_q && grant_ok
            && (op_a[win]  == c_op_q)
            && (op1_a[win] == c_op1_q)
            && (op2_a[win] == c_op2_q);

  assign div_vld_o = grant_ok && !hit;
  assign issue     = div_vld_o && div_rdy_i;
  assign accept    = hit || issue;

  always_comb begin
    req_rdy_o = '0;
    if (grant_ok && (hit || div_rdy_i)) begin
      req_rdy_o[win] = 1'b1;
    end
  end

  assign div_op_o       = grant_ok ? op_a[win]  : '0;
  assign div_op1_o      = grant_ok ? op1_a[win] : '0;
  assign div_op2_o      = grant_ok ? op2_a[win] : '0;
  assign div_trans_id_o = grant_ok ? id_a[win]  : '0;

  logic in_resp;
  assign in_resp = (state_q == RESP);

  assign wb_vld_o      = in_resp;
  assign wb_result_o   = in_resp ? buf_res_q : '0;
  assign wb_trans_id_o = in_resp ? buf_id_q  : '0;
  assign wb_src_o      = in_resp ? buf_src_q : '0;
  assign busy_o        = (state_q != IDLE);
  assign err_o         = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      lat_op_q  <= '0;
      lat_op1_q <= '0;
      lat_op2_q <= '0;
      lat_src_q <= '0;
      buf_res_q <= '0;
      buf_id_q  <= '0;
      buf_src_q <= '0;
      c_vld_q   <= 1'b0;
      c_op_q    <= '0;
      c_op1_q   <= '0;
      c_op2_q   <= '0;
      c_res_q   <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
    end else if (flush_ex_i) begin
      state_q <= IDLE;
      wd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rr_q <= rr_nxt;
          end
          if (hit) begin
            buf_res_q <= c_res_q;
            buf_id_q  <= id_a[win];
            buf_src_q <= win;
            state_q   <= RESP;
          end else if (issue) begin
            lat_op_q  <= op_a[win];
            lat_op1_q <= op1_a[win];
            lat_op2_q <= op2_a[win];
            lat_src_q <= win;
            wd_q      <= '0;
            if (div_vld_i) begin
              buf_res_q <= div_result_i;
              buf_id_q  <= div_trans_id_i;
              buf_src_q <= win;
              state_q   <= RESP;
            end else begin
              state_q   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (div_vld_i) begin
            buf_res_q <= div_result_i;
            buf_id_q  <= div_trans_id_i;
            buf_src_q <= lat_src_q;
            c_vld_q   <= 1'b1;
            c_op_q    <= lat_op_q;
            c_op1_q   <= lat_op1_q;
            c_op2_q   <= lat_op2_q;
            c_res_q   <= div_result_i;
            state_q   <= RESP;
          end else begin
            // Saturating count; error raised as the count reaches MAX_LAT.
            if (wd_q != WD_W'(MAX_LAT)) begin
              wd_q <= wd_q + 1'b1;
            end
            if (wd_q == WD_W'(MAX_LAT - 1)) begin
              err_q <= 1'b1;
            end
          end
        end
        RESP: begin
          if (wb_rdy_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl; the divider is modelled by
// hand-driven div_rdy_i / div_vld_i / div_result_i.
module tb_div_ctrl;

  localparam int N  = 2;
  localparam int OW = 2;
  localparam int AB = 4;
  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_ex_i;
  logic [N-1:0]  req_vld_i;
  logic [N-1:0]  req_rdy_o;
  logic [N*OW-1:0] req_op_i;
  logic [N*32-1:0] req_op1_i;
  logic [N*32-1:0] req_op2_i;
  logic [N*AB-1:0] req_trans_id_i;
  logic          div_vld_o;
  logic          div_rdy_i;
  logic [OW-1:0] div_op_o;
  logic [31:0]   div_op1_o;
  logic [31:0]   div_op2_o;
  logic [AB-1:0] div_trans_id_o;
  logic          div_vld_i;
  logic [AB-1:0] div_trans_id_i;
  logic [31:0]   div_result_i;
  logic          wb_vld_o;
  logic          wb_rdy_i;
  logic [AB-1:0] wb_trans_id_o;
  logic [31:0]   wb_result_o;
  logic [0:0]    wb_src_o;
  logic          busy_o;
  logic          err_o;

  int total  = 0;
  int passed = 0;

  div_ctrl #(
    .NUM_REQ(N), .CACHE_EN(1'b1), .MAX_LAT(40),
    .OP_W(OW), .ADDR_BITS(AB)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_ex_i(flush_ex_i),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o),
    .req_op_i(req_op_i), .req_op1_i(req_op1_i),
    .req_op2_i(req_op2_i), .req_trans_id_i(req_trans_id_i),
    .div_vld_o(div_vld_o), .div_rdy_i(div_rdy_i),
    .div_op_o(div_op_o), .div_op1_o(div_op1_o),
    .div_op2_o(div_op2_o), .div_trans_id_o(div_trans_id_o),
    .div_vld_i(div_vld_i), .div_trans_id_i(div_trans_id_i),
    .div_result_i(div_result_i),
    .wb_vld_o(wb_vld_o), .wb_rdy_i(wb_rdy_i),
    .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o),
    .wb_src_o(wb_src_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [AB-1:0] id);
    req_op_i[i*OW +: OW]       = op;
    req_op1_i[i*32 +: 32]      = a;
    req_op2_i[i*32 +: 32]      = b;
    req_trans_id_i[i*AB +: AB] = id;
  endtask

  task automatic wb_ack();
    wb_rdy_i = 1'b1;
    tick();
    wb_rdy_i = 1'b0;
  endtask

  logic [AB-1:0] ids [N];
  logic [31:0]   keep_res;

  initial begin
    rst_ni = 1'b0; flush_ex_i = 1'b0;
    req_vld_i = '1; req_op_i = '0; req_op1_i = '0;
    req_op2_i = '0; req_trans_id_i = '0;
    div_rdy_i = 1'b1; div_vld_i = 1'b0;
    div_trans_id_i = '0; div_result_i = '0;
    wb_rdy_i = 1'b0;
    tick(); tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_wb_vld", wb_vld_o, 0);
    chk("rst_div_vld", div_vld_o, 0);
    chk("rst_req_rdy", req_rdy_o, 0);
    req_vld_i = '0;
    rst_ni = 1'b1;
    tick();

    // 1: round robin with both requesters always valid, fast path
    ids[0] = 4'h0; ids[1] = 4'h1;
    req_vld_i = 2'b11;
    for (int k = 0; k < 6; k++) begin
      set_req(0, OP_DIVU, 32'(k + 10), 32'd3, ids[0]);
      set_req(1, OP_DIVU, 32'(k + 20), 32'd3, ids[1]);
      #1;
      chk("rr_div_vld", div_vld_o, 1);
      chk("rr_rdy", req_rdy_o, 64'(1 << (k % 2)));
      chk("rr_div_id", div_trans_id_o, ids[k % 2]);
      div_vld_i = 1'b1;
      div_trans_id_i = ids[k % 2];
      div_result_i = 32'h100 + 32'(k);
      tick();
      div_vld_i = 1'b0;
      chk("rr_wb_vld", wb_vld_o, 1);
      chk("rr_wb_src", wb_src_o, 64'(k % 2));
      chk("rr_wb_id", wb_trans_id_o, ids[k % 2]);
      chk("rr_wb_res", wb_result_o, 32'h100 + 32'(k));
      chk("rr_resp_rdy", req_rdy_o, 0);
      wb_ack();
      ids[k % 2] = ids[k % 2] + 4'd2;
    end
    req_vld_i = '0;
    #1;
    chk("rr_idle", busy_o, 0);

    // 2: DIVU 5/0 on req 0, fast path
    set_req(0, OP_DIVU, 32'd5, 32'd0, 4'hA);
    req_vld_i = 2'b01;
    #1;
    chk("fp_div_vld", div_vld_o, 1);
    chk("fp_div_op", div_op_o, OP_DIVU);
    chk("fp_div_op1", div_op1_o, 5);
    chk("fp_div_op2", div_op2_o, 0);
    div_vld_i = 1'b1; div_trans_id_i = 4'hA;
    div_result_i = 32'hFFFF_FFFF;
    tick();
    div_vld_i = 1'b0; req_vld_i = '0;
    chk("fp_wb_vld", wb_vld_o, 1);
    chk("fp_wb_res", wb_result_o, 32'hFFFF_FFFF);
    chk("fp_wb_id", wb_trans_id_o, 4'hA);
    wb_ack();
    chk("fp_idle", busy_o, 0);
    chk("fp_wb_drop", wb_vld_o, 0);

    // 3: DIV 100 / -7 then REM, iterative
    set_req(0, OP_DIV, 32'd100, 32'hFFFF_FFF9, 4'h3);
    req_vld_i = 2'b01;
    tick();
    req_vld_i = '0;
    chk("it_busy", busy_o, 1);
    chk("it_no_wb", wb_vld_o, 0);
    chk("it_no_issue", div_vld_o, 0);
    tick(); tick();
    div_vld_i = 1'b1; div_trans_id_i = 4'h3;
    div_result_i = 32'hFFFF_FFF2;
    tick();
    div_vld_i = 1'b0;
    chk("div_wb_vld", wb_vld_o, 1);
    chk("div_wb_res", wb_result_o, 32'hFFFF_FFF2);
    chk("div_wb_id", wb_trans_id_o, 4'h3);
    wb_ack();
    set_req(0, OP_REM, 32'd100, 32'hFFFF_FFF9, 4'h5);
    req_vld_i = 2'b01;
    #1;
    chk("rem_miss", div_vld_o, 1);
    tick();
    req_vld_i = '0;
    tick();
    div_vld_i = 1'b1; div_trans_id_i = 4'h5;
    div_result_i = 32'h0000_0002;
    tick();
    div_vld_i = 1'b0;
    chk("rem_wb_res", wb_result_o, 2);
    chk("rem_wb_id", wb_trans_id_o, 4'h5);
    wb_ack();

    // 4: same REM on req 1 hits the cache
    set_req(1, OP_REM, 32'd100, 32'hFFFF_FFF9, 4'h9);
    req_vld_i = 2'b10;
    #1;
    chk("hit_div_vld", div_vld_o, 0);
    chk("hit_rdy", req_rdy_o, 2'b10);
    tick();
    chk("hit_wb_vld", wb_vld_o, 1);
    chk("hit_wb_res", wb_result_o, 2);
    chk("hit_wb_id", wb_trans_id_o, 4'h9);
    chk("hit_wb_src", wb_src_o, 1);

    // 5: writeback stall for 10 cycles
    req_vld_i = 2'b11;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("st_wb_vld", wb_vld_o, 1);
      chk("st_wb_res", wb_result_o, 2);
      chk("st_wb_id", wb_trans_id_o, 4'h9);
      chk("st_rdy", req_rdy_o, 0);
      chk("st_div_vld", div_vld_o, 0);
    end
    req_vld_i = '0;
    wb_ack();
    chk("st_idle", busy_o, 0);

    // 6a: flush mid-BUSY; late result ignored, cache untouched
    set_req(0, OP_DIV, 32'd7, 32'd2, 4'h6);
    req_vld_i = 2'b01;
    tick();
    req_vld_i = '0;
    tick(); tick();
    chk("fl_busy", busy_o, 1);
    flush_ex_i = 1'b1;
    req_vld_i = 2'b01;
    #1;
    chk("fl_no_issue", div_vld_o, 0);
    chk("fl_no_rdy", req_rdy_o, 0);
    tick();
    flush_ex_i = 1'b0;
    req_vld_i = '0;
    chk("fl_idle", busy_o, 0);
    chk("fl_no_wb", wb_vld_o, 0);
    div_vld_i = 1'b1; div_trans_id_i = 4'h6;
    div_result_i = 32'd3;
    tick();
    div_vld_i = 1'b0;
    chk("late_no_wb", wb_vld_o, 0);
    chk("late_idle", busy_o, 0);
    div_rdy_i = 1'b0;
    req_vld_i = 2'b01;
    #1;
    chk("fl_miss", div_vld_o, 1);
    chk("fl_miss_rdy", req_rdy_o, 0);
    set_req(0, OP_REM, 32'd100, 32'hFFFF_FFF9, 4'hC);
    #1;
    chk("kept_hit", div_vld_o, 0);
    chk("kept_rdy", req_rdy_o, 2'b01);
    tick();
    req_vld_i = '0;
    div_rdy_i = 1'b1;
    chk("kept_res", wb_result_o, 2);
    chk("kept_id", wb_trans_id_o, 4'hC);
    keep_res = wb_result_o;
    wb_ack();

    // 6b: reset invalidates cache; watchdog with silent divider
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    req_vld_i = 2'b01;
    #1;
    chk("rst_miss", div_vld_o, 1);
    tick();
    req_vld_i = '0;
    for (int k = 0; k < 39; k++) tick();
    chk("wd_39_busy", busy_o, 1);
    chk("wd_39_err", err_o, 0);
    tick();
    chk("wd_40_err", err_o, 1);
    chk("wd_40_busy", busy_o, 1);
    flush_ex_i = 1'b1;
    tick();
    flush_ex_i = 1'b0;
    tick();
    chk("wd_sticky", err_o, 1);
    chk("wd_idle", busy_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Shares the single iterative divider among NUM_REQ issue requesters. Each cycle it picks one request by round-robin and forwards it to the divider. It then captures the divider's single-cycle result pulse into a holding buffer and presents that result on a valid/ready writeback port. A one-entry result cache returns repeated identical divisions without occupying the divider. A watchdog flags a divider that never responds.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
CACHE_EN, 1, enables the one-entry repeat-operand result cache
MAX_LAT, 40, BUSY cycles allowed before err_o is set
SRC_W, $clog2(NUM_REQ), requester index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
flush_ex_i  in  1  kill in-flight op and held result
req_vld_i  in  NUM_REQ  per-requester valid
req_rdy_o  out  NUM_REQ  per-requester accept
req_op_i  in  NUM_REQ x fu_op_t  operation (DIV/DIVU/REM/REMU)
req_op1_i  in  NUM_REQ x 32  dividend
req_op2_i  in  NUM_REQ x 32  divisor
req_trans_id_i  in  NUM_REQ x ADDR_BITS  transaction id
div_vld_o  out  1  issue valid to divider
div_rdy_i  in  1  divider ready
div_op_o  out  fu_op_t  granted op
div_op1_o, div_op2_o  out  32 each  granted operands
div_trans_id_o  out  ADDR_BITS  granted id
div_vld_i  in  1  divider result pulse (no backpressure)
div_trans_id_i  in  ADDR_BITS  result id
div_result_i  in  32  result
wb_vld_o  out  1  writeback valid
wb_rdy_i  in  1  writeback accept
wb_trans_id_o  out  ADDR_BITS  result id
wb_result_o  out  32  result
wb_src_o  out  SRC_W  requester that issued the result
busy_o  out  1  state != IDLE
err_o  out  1  sticky watchdog error

Behaviour:
- Reset (rst_ni=0 at clk edge): state=IDLE, rr_q=0, cache invalid, watchdog=0. Every output is 0.
- States:
  - IDLE: may accept one request.
  - BUSY: op issued, waiting for div_vld_i.
  - RESP: result held, wb_vld_o=1.
- Grant (IDLE only, flush_ex_i=0):
  - Winner w = first requester with req_vld_i set, scanning from rr_q upward and wrapping.
  - div_*_o carry w's fields combinationally. In other states they are 0.
- Cache hit (CACHE_EN, cache valid, w's {op,op1,op2} equal the cached tuple):
  - div_vld_o=0.
  - req_rdy_o[w]=1.
  - Buffer loads the cached result, req_trans_id_i[w] and src=w.
  - Next state RESP.
- Cache miss:
  - div_vld_o=1.
  - req_rdy_o[w] = div_rdy_i. No other req_rdy_o bit is ever set.
  - On handshake, latch {op,op1,op2,src=w}.
  - If div_vld_i is set in the same cycle (divider fast path), capture div_result_i/div_trans_id_i and go to RESP. Otherwise go to BUSY.
- Any accept (hit or handshake): rr_q <= (w+1) mod NUM_REQ.
- BUSY:
  - On div_vld_i: capture result and id, write cache {latched op,op1,op2,result} and set it valid, go to RESP.
  - Watchdog counts BUSY cycles. When count == MAX_LAT, err_o=1 (sticky until reset). State stays BUSY.
- RESP:
  - wb_vld_o=1. wb_result_o, wb_trans_id_o and wb_src_o stay stable until wb_rdy_i.
  - On handshake go to IDLE. There is no issue in the handshake cycle, so back-to-back throughput is one op per 2 cycles minimum.
  - req_rdy_o=0 throughout RESP.
- div_vld_i outside the BUSY state or the IDLE issue cycle: ignored.
- Latency: accept at cycle N gives wb_vld_o at N+1 for a cache hit or fast path. For the iterative path, wb_vld_o is asserted the cycle after div_vld_i.
- flush_ex_i (highest priority, any state):
  - div_vld_o=0 and req_rdy_o=0 in that cycle.
  - Next state IDLE, wb_vld_o drops, watchdog cleared.
  - rr_q and cache contents retained. An in-flight result is not written to the cache.
  - flush_ex_i also reaches the divider directly.
- Simultaneous flush and wb handshake: flush wins. The result is dropped and the consumer must tolerate this.
- Reset mid-BUSY: IDLE, cache invalid. The divider resets on the same rst_ni.

Test Plan:
1. req_vld_i=2'b11 every cycle, each with a unique trans_id, 6 requests → grants alternate 0,1,0,1,0,1; wb_src_o follows the same sequence; no request starves.
2. DIVU op1=5, op2=0 on req 0 → divider fast path, wb_result_o=0xFFFF_FFFF at N+1, wb_trans_id_o = issued id.
3. DIV op1=100, op2=0xFFFF_FFF9 (−7) → after div_vld_i, wb_result_o=0xFFFF_FFF2. REM with the same operands → 0x0000_0002.
4. Repeat item 3's REM on req 1 with a new id → div_vld_o stays 0, wb_result_o=2 at N+1, new id, wb_src_o=1.
5. wb_rdy_i=0 for 10 cycles in RESP → wb outputs stable, req_rdy_o=0, div_vld_o=0. Then wb_rdy_i=1 → IDLE next cycle.
6. Flush 3 cycles into BUSY → IDLE next cycle, no wb_vld_o, the late div_vld_i is ignored, and the next identical request misses the cache. A separate run holds div_vld_i low → err_o=1 after 40 BUSY cycles.
